matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter COMPUTE_CYCLES, default 24: number of compute-phase cycles (at least 22).
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port START  in  1  run request, sampled only in IDLE.
REQ-005 SHALL have ports IN_VALID in 1, IN_READY out 1, IN_DATA in 16: operand stream, transfer when IN_VALID&IN_READY.
REQ-006 SHALL have ports OUT_VALID out 1, OUT_READY in 1, OUT_DATA out 16: result stream, transfer when OUT_VALID&OUT_READY.
REQ-007 SHALL have ports BUSY out 1 (not IDLE) and DONE out 1 (one-cycle end-of-run pulse).
REQ-008 SHALL have controller-side ports, all out: C_EN 1, C_WRITE 1, C_LOAD 1, C_IDX 3, C_REG_SELECT 4, C_DATA_IN 16, C_RST 1.
REQ-009 SHALL have controller-side port C_DATA_OUT  in  16: result word from the controller.

Function
REQ-010 SHALL implement states IDLE, CLR, FILL, LOAD, COMPUTE, RD_ISSUE, RD_WAIT, RD_CAP, OUT_HOLD, FIN.
REQ-011 SHALL register every controller-side output except C_RST; a command decided in cycle t is on the ports in cycle t+1.
REQ-012 SHALL drive C_EN=0 in IDLE, CLR, RD_WAIT, RD_CAP, OUT_HOLD and FIN, so the controller holds.
REQ-013 IDLE with START=1 SHALL go to CLR; BUSY rises the next cycle.
REQ-014 CLR SHALL last 1 cycle with C_RST=1 to clear the array accumulators, then go to FILL.
REQ-015 C_RST SHALL equal RST OR (state==CLR).
REQ-016 FILL SHALL assert IN_READY and accept exactly 128 words, counter k=0..127.
REQ-017 For word k, FILL SHALL issue one controller write: C_EN=1, C_LOAD=0, C_WRITE=1, C_REG_SELECT=k[6:3], C_IDX=k[2:0], C_DATA_IN=IN_DATA.
REQ-018 Word order SHALL be A0[0..7], A1, ..., A7, then B0..B7, each register holding 8 elements.
REQ-019 FILL cycles without a handshake SHALL drive C_EN=0; IN_VALID gaps of any length SHALL be tolerated.
REQ-020 After word 127 is accepted, IN_READY SHALL drop the next cycle and the state SHALL go to LOAD.
REQ-021 LOAD SHALL issue exactly 8 consecutive cycles of C_EN=1, C_LOAD=1, C_WRITE=0, returning the controller's internal index counter to 0.
REQ-022 COMPUTE SHALL issue exactly COMPUTE_CYCLES cycles of C_EN=1, C_LOAD=0, C_WRITE=0, then go to RD_ISSUE.
REQ-023 Read counter j=0..63 SHALL select C_REG_SELECT={1'b0,j[5:3]}, C_IDX=j[2:0].
REQ-024 RD_ISSUE SHALL issue one read command: C_EN=1, C_LOAD=1, C_WRITE=1.
REQ-025 RD_WAIT SHALL last 1 cycle.
REQ-026 RD_CAP SHALL latch C_DATA_OUT into OUT_DATA (two cycles after the command is on the ports), then go to OUT_HOLD.
REQ-027 OUT_HOLD SHALL hold OUT_VALID=1 and OUT_DATA stable until OUT_READY=1.
REQ-028 After each OUT_HOLD handshake, SHALL go to RD_ISSUE with j+1, or to FIN after j=63.
REQ-029 OUT_VALID SHALL not depend combinationally on OUT_READY.
REQ-030 FIN SHALL pulse DONE=1 for 1 cycle with BUSY still 1, then go to IDLE.
REQ-031 START while BUSY SHALL be ignored.
REQ-032 START in FIN SHALL be ignored; a new run needs START in IDLE.
REQ-033 k, j and the compute counter SHALL be sized to their ranges and SHALL clear on entry to their state.

Reset
REQ-034 RST=1 SHALL force, on the next edge: IDLE, all counters 0, IN_READY=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0.
REQ-035 RST=1 SHALL likewise force C_EN=0, C_WRITE=0, C_LOAD=0, C_IDX=0, C_REG_SELECT=0, C_DATA_IN=0.
REQ-036 RST in any state, including mid-FILL, mid-LOAD or OUT_HOLD, SHALL abort the run; no DONE and no further OUT_VALID for that run.
REQ-037 A run following an abort SHALL produce correct results, since CLR clears accumulators and FILL rewrites all 128 operands.

Verification (bench: sequencer + controller + array)
REQ-038 All A=2, all B=3, IN_VALID always 1, OUT_READY always 1 -> exactly 64 outputs, each 48, then one DONE pulse.
REQ-039 Same operands, IN_VALID 1 on alternate cycles, OUT_READY low 3 of 4 cycles -> same 64 values; OUT_DATA stable while stalled; C_EN=0 on gap cycles.
REQ-040 Back-to-back runs A=2/B=3 then A=1/B=1 -> second run yields 64 values of 8, not 56, proving CLR clears accumulators.
REQ-041 RST asserted at FILL word 40, then full run with A=1/B=5 -> no DONE before RST; run after yields 64 values of 40.
REQ-042 START pulsed during COMPUTE and during FIN -> no second run; BUSY falls exactly 1 cycle after DONE.
REQ-043 Port monitor -> per run exactly 128 write, 8 load, COMPUTE_CYCLES compute and 64 read commands, each with REQ-017/REQ-023 encoding.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Operand and result stream bundle between a host and the matmul sequencer.
interface matmul_sequencer_if;
  localparam int unsigned DATA_W = 16;

  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;

  // Host side: sources operands, sinks results.
  modport master (
    output IN_VALID,
    output IN_DATA,
    input  IN_READY,
    input  OUT_VALID,
    input  OUT_DATA,
    output OUT_READY
  );

  // Sequencer side: sinks operands, sources results.
  modport slave (
    input  IN_VALID,
    input  IN_DATA,
    output IN_READY,
    output OUT_VALID,
    output OUT_DATA,
    input  OUT_READY
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Run sequencer for an 8x8 matrix-multiply controller: clears the array,
// streams 128 operands in, loads, computes, then reads 64 results out.
module matmul_sequencer #(
  parameter int unsigned COMPUTE_CYCLES = 24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  matmul_sequencer_if.slave bus,
  output logic        BUSY,
  output logic        DONE,
  output logic        C_EN,
  output logic        C_WRITE,
  output logic        C_LOAD,
  output logic [2:0]  C_IDX,
  output logic [3:0]  C_REG_SELECT,
  output logic [15:0] C_DATA_IN,
  output logic        C_RST,
  input  logic [15:0] C_DATA_OUT
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned K_W    = 7;
  localparam int unsigned L_W    = 3;
  localparam int unsigned J_W    = 6;
  localparam int unsigned CC_W   = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [K_W-1:0]  K_LAST  = K_W'(127);
  localparam logic [L_W-1:0]  L_LAST  = L_W'(7);
  localparam logic [J_W-1:0]  J_LAST  = J_W'(63);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(COMPUTE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, CLR, FILL, LOAD, COMPUTE, RD_ISSUE, RD_WAIT, RD_CAP, OUT_HOLD, FIN
  } state_t;

  state_t state_q, state_d;

  logic [K_W-1:0]  k_q,  k_d;
  logic [L_W-1:0]  ld_q, ld_d;
  logic [CC_W-1:0] cc_q, cc_d;
  logic [J_W-1:0]  j_q,  j_d;

  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  logic              c_en_q,    c_en_d;
  logic              c_write_q, c_write_d;
  logic              c_load_q,  c_load_d;
  logic [2:0]        c_idx_q,   c_idx_d;
  logic [3:0]        c_sel_q,   c_sel_d;
  logic [DATA_W-1:0] c_din_q,   c_din_d;

  // Next state, counters and the command to present on the controller next cycle.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ld_d       = ld_q;
    cc_d       = cc_q;
    j_d        = j_q;
    out_data_d = out_data_q;
    c_en_d     = 1'b0;
    c_write_d  = 1'b0;
    c_load_d   = 1'b0;
    c_idx_d    = '0;
    c_sel_d    = '0;
    c_din_d    = '0;

    case (state_q)
      IDLE: begin
        if (START) state_d = CLR;
      end
      CLR: begin
        k_d     = '0;
        state_d = FILL;
      end
      FILL: begin
        if (bus.IN_VALID && in_ready_q) begin
          c_en_d    = 1'b1;
          c_write_d = 1'b1;
          c_sel_d   = k_q[6:3];
          c_idx_d   = k_q[2:0];
          c_din_d   = bus.IN_DATA;
          if (k_q == K_LAST) begin
            ld_d    = '0;
            state_d = LOAD;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      LOAD: begin
        c_en_d   = 1'b1;
        c_load_d = 1'b1;
        if (ld_q == L_LAST) begin
          cc_d    = '0;
          state_d = COMPUTE;
        end else begin
          ld_d = ld_q + L_W'(1);
        end
      end
      COMPUTE: begin
        c_en_d = 1'b1;
        if (cc_q == CC_LAST) begin
          j_d     = '0;
          state_d = RD_ISSUE;
        end else begin
          cc_d = cc_q + CC_W'(1);
        end
      end
      RD_ISSUE: begin
        c_en_d    = 1'b1;
        c_load_d  = 1'b1;
        c_write_d = 1'b1;
        c_sel_d   = {1'b0, j_q[5:3]};
        c_idx_d   = j_q[2:0];
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        out_data_d = C_DATA_OUT;
        state_d    = OUT_HOLD;
      end
      OUT_HOLD: begin
        if (bus.OUT_READY) begin
          if (j_q == J_LAST) begin
            state_d = FIN;
          end else begin
            j_d     = j_q + J_W'(1);
            state_d = RD_ISSUE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == OUT_HOLD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
  end

  // State, counters and every registered output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      k_q         <= '0;
      ld_q        <= '0;
      cc_q        <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      c_en_q      <= 1'b0;
      c_write_q   <= 1'b0;
      c_load_q    <= 1'b0;
      c_idx_q     <= '0;
      c_sel_q     <= '0;
      c_din_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ld_q        <= ld_d;
      cc_q        <= cc_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      c_en_q      <= c_en_d;
      c_write_q   <= c_write_d;
      c_load_q    <= c_load_d;
      c_idx_q     <= c_idx_d;
      c_sel_q     <= c_sel_d;
      c_din_q     <= c_din_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign C_EN          = c_en_q;
  assign C_WRITE       = c_write_q;
  assign C_LOAD        = c_load_q;
  assign C_IDX         = c_idx_q;
  assign C_REG_SELECT  = c_sel_q;
  assign C_DATA_IN     = c_din_q;

  // Accumulator clear follows reset immediately, and CLR for one cycle per run.
  assign C_RST = RST | (state_q == CLR);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: sequencer driving a behavioural controller/array model,
// results scored against a plain matrix product of the streamed operands.
module tb_matmul_sequencer;
  localparam int unsigned CC     = 24;
  localparam int          NWORDS = 128;
  localparam int          NRES   = 64;

  logic        CLK = 1'b0;
  logic        RST, START, BUSY, DONE;
  logic        C_EN, C_WRITE, C_LOAD, C_RST;
  logic [2:0]  C_IDX;
  logic [3:0]  C_REG_SELECT;
  logic [15:0] C_DATA_IN, C_DATA_OUT;

  matmul_sequencer_if bus ();

  matmul_sequencer #(.COMPUTE_CYCLES(CC)) dut (
    .CLK(CLK), .RST(RST), .START(START), .bus(bus),
    .BUSY(BUSY), .DONE(DONE),
    .C_EN(C_EN), .C_WRITE(C_WRITE), .C_LOAD(C_LOAD), .C_IDX(C_IDX),
    .C_REG_SELECT(C_REG_SELECT), .C_DATA_IN(C_DATA_IN), .C_RST(C_RST),
    .C_DATA_OUT(C_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_mode = 0;
  logic [15:0] cur_words [NWORDS];
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller/array model: 16 operand registers of 8 words; results land
  // in the accumulators after a full compute burst; reads return one cycle later.
  logic [15:0] opr [16][8];
  logic [15:0] acc [8][8];
  int unsigned cmp_cnt;

  function automatic logic [15:0] dot(input int r, input int c);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + 16'(opr[r][k] * opr[8+k][c]);
    return s;
  endfunction

  always @(posedge CLK) begin
    if (C_RST) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) acc[r][c] <= '0;
      cmp_cnt <= 0;
    end else if (C_EN) begin
      case ({C_LOAD, C_WRITE})
        2'b01: opr[C_REG_SELECT][C_IDX] <= C_DATA_IN;
        2'b10: cmp_cnt <= 0;
        2'b00: begin
          cmp_cnt <= cmp_cnt + 1;
          if (cmp_cnt == CC - 1)
            for (int r = 0; r < 8; r++)
              for (int c = 0; c < 8; c++) acc[r][c] <= acc[r][c] + dot(r, c);
        end
        default: C_DATA_OUT <= acc[C_REG_SELECT[2:0]][C_IDX];
      endcase
    end
  end

  // Reference: C = A x B, A rows are words 0..63, B rows are words 64..127.
  task automatic push_expected();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int unsigned s;
        s = 0;
        for (int k = 0; k < 8; k++)
          s += 32'(cur_words[r*8+k]) * 32'(cur_words[64+k*8+c]);
        exp_q.push_back(16'(s));
      end
  endtask

  task automatic set_words(input bit rnd, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < NWORDS; i++)
      cur_words[i] = rnd ? 16'($urandom) : ((i < 64) ? a : b);
  endtask

  // Result sink readiness pattern.
  initial begin
    int ocyc;
    ocyc = 0;
    bus.OUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (stall_mode)
        0:       bus.OUT_READY = 1'b1;
        1:       bus.OUT_READY = ((ocyc % 4) == 3);
        default: bus.OUT_READY = 1'($urandom_range(0, 1));
      endcase
      ocyc++;
    end
  end

  // Result monitor: pops the scoreboard on each handshake, checks stalls hold.
  initial begin
    bit hold_pend;
    logic [15:0] held;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("out_valid_held", 32'(bus.OUT_VALID), 32'(1));
          check("out_data_stable", 32'(bus.OUT_DATA), 32'(held));
        end
        if (bus.OUT_VALID && bus.OUT_READY) begin
          if (exp_q.size() == 0) check("unexpected_output", 32'(bus.OUT_DATA), 32'hDEAD_BEEF);
          else check("out_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
        end
        hold_pend = bus.OUT_VALID && !bus.OUT_READY;
        held = bus.OUT_DATA;
      end
    end
  end

  // Controller port monitor: per-run command counts and encodings.
  initial begin
    int wr_n, ld_n, cp_n, rd_n, crst_n;
    wr_n = 0; ld_n = 0; cp_n = 0; rd_n = 0; crst_n = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        wr_n = 0; ld_n = 0; cp_n = 0; rd_n = 0; crst_n = 0;
      end else begin
        if (C_RST) crst_n++;
        if (C_EN) begin
          case ({C_LOAD, C_WRITE})
            2'b01: begin
              check("wr_sel", 32'(C_REG_SELECT), 32'((wr_n >> 3) & 15));
              check("wr_idx", 32'(C_IDX), 32'(wr_n & 7));
              if (wr_n < NWORDS) check("wr_data", 32'(C_DATA_IN), 32'(cur_words[wr_n]));
              wr_n++;
            end
            2'b10: ld_n++;
            2'b00: cp_n++;
            default: begin
              check("rd_sel", 32'(C_REG_SELECT), 32'((rd_n >> 3) & 7));
              check("rd_idx", 32'(C_IDX), 32'(rd_n & 7));
              rd_n++;
            end
          endcase
        end
        if (DONE) begin
          check("busy_with_done", 32'(BUSY), 32'(1));
          check("n_write", 32'(wr_n), 32'(128));
          check("n_load", 32'(ld_n), 32'(8));
          check("n_compute", 32'(cp_n), 32'(CC));
          check("n_read", 32'(rd_n), 32'(64));
          check("n_clear", 32'(crst_n), 32'(1));
          wr_n = 0; ld_n = 0; cp_n = 0; rd_n = 0; crst_n = 0;
          done_cnt++;
        end
      end
    end
  end

  // One run: START in IDLE, stream operands, optionally abort, await DONE.
  task automatic run_once(input int gap_mode, input int abort_at, input bit start_probe);
    int k, guard, phase, done0;
    bit hs, v, seen;
    done0 = done_cnt;
    guard = 0;
    while (BUSY && guard < 200) begin
      @(posedge CLK); #1; guard++;
    end
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    if (abort_at < 0) push_expected();

    k = 0; guard = 0; phase = 0;
    while (k < NWORDS && guard < 4000) begin
      if (abort_at >= 0 && k == abort_at) break;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ((phase % 2) == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.IN_VALID = v;
      bus.IN_DATA  = v ? cur_words[k] : 16'($urandom);
      phase++;
      @(negedge CLK);
      hs = bus.IN_VALID && bus.IN_READY;
      @(posedge CLK); #1;
      if (hs) k++;
      guard++;
    end
    bus.IN_VALID = 1'b0;

    if (abort_at >= 0) begin
      check("abort_point", 32'(k), 32'(abort_at));
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("abort_busy", 32'(BUSY), 32'(0));
      check("abort_in_ready", 32'(bus.IN_READY), 32'(0));
      repeat (300) @(negedge CLK);
      check("abort_no_done", 32'(done_cnt), 32'(done0));
      return;
    end
    check("fill_complete", 32'(k), 32'(NWORDS));

    if (start_probe) begin
      repeat (12) @(posedge CLK);
      #1; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
    end

    guard = 0; seen = 1'b0;
    while (!seen && guard < 20000) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
      else guard++;
    end
    check("done_seen", 32'(seen), 32'(1));
    if (seen) begin
      if (start_probe) START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      @(negedge CLK);
      check("busy_after_done", 32'(BUSY), 32'(0));
      check("done_one_cycle", 32'(DONE), 32'(0));
      repeat (5) @(negedge CLK);
      check("no_restart", 32'(BUSY), 32'(0));
    end
    check("results_drained", 32'(exp_q.size()), 32'(0));
    check("done_once", 32'(done_cnt), 32'(done0 + 1));
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", 32'(bus.IN_READY), 32'(0));
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'(0));
    check("rst_out_data", 32'(bus.OUT_DATA), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_done", 32'(DONE), 32'(0));
    check("rst_cmd", 32'({C_EN, C_WRITE, C_LOAD, C_IDX, C_REG_SELECT}), 32'(0));
    check("rst_c_data_in", 32'(C_DATA_IN), 32'(0));
    check("rst_c_rst", 32'(C_RST), 32'(1));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("idle_c_rst", 32'(C_RST), 32'(0));
    check("idle_busy", 32'(BUSY), 32'(0));
    @(posedge CLK); #1;

    stall_mode = 0; set_words(1'b0, 16'd2, 16'd3); run_once(0, -1, 1'b0);
    stall_mode = 1; set_words(1'b0, 16'd2, 16'd3); run_once(1, -1, 1'b0);
    stall_mode = 0; set_words(1'b0, 16'd1, 16'd1); run_once(0, -1, 1'b0);
    stall_mode = 2; set_words(1'b1, 16'd0, 16'd0); run_once(2, 40, 1'b0);
    stall_mode = 0; set_words(1'b0, 16'd1, 16'd5); run_once(0, -1, 1'b0);
    stall_mode = 0; set_words(1'b0, 16'd2, 16'd3); run_once(0, -1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      stall_mode = 2;
      set_words(1'b1, 16'd0, 16'd0);
      run_once(2, -1, 1'b0);
    end
    check("total_done", 32'(done_cnt), 32'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
